// File: rtl/i2c_reg_ctrl_pkg.sv
// i2c_reg_ctrl_pkg: shared types and defaults for the I2C register-map controller.
package i2c_reg_ctrl_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned DEFAULT_ADDR_W = 4;
   localparam logic [BYTE_W-1:0] DEFAULT_RESET_VAL = 8'h00;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDRESSED = 2'd1,
      WRITE     = 2'd2,
      READ      = 2'd3
   } state_t;

   // The slave shifts bytes MSB-first into index 0, so its buffers are bit-reversed values.
   function automatic logic [BYTE_W-1:0] bit_rev(input logic [BYTE_W-1:0] b);
      return {<<{b}};
   endfunction

endpackage

// File: rtl/i2c_reg_ctrl_edge_detect.sv
// edge_detect: one-flop history giving combinational rise/fall strobes.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise_c,
   output logic fall_c
);

   logic prev_q;

   // Remember last cycle's level.
   always_ff @(posedge clk) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= din;
   end

   assign rise_c = din & ~prev_q;
   assign fall_c = ~din & prev_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: pointer-addressed register file sequenced by the i2c_slave byte handshake.
// Optional macro I2C_REG_CTRL_WRITE_PROTECT_EN makes indices >= RO_BASE read-only over I2C.
module i2c_reg_ctrl
   import i2c_reg_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   parameter int unsigned RO_BASE = 12,
`endif
   parameter logic [BYTE_W-1:0] RESET_VAL = DEFAULT_RESET_VAL
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 slave_asserted,
   input  logic                                 slave_in_tx_mode,
   input  logic                                 slave_tx_request,
   input  logic [BYTE_W-1:0]                    slave_rx_buffer,
   input  logic                                 slave_rx_available,
   output logic [BYTE_W-1:0]                    slave_tx_buffer,
   input  logic                                 host_we,
   input  logic [ADDR_W-1:0]                    host_addr,
   input  logic [BYTE_W-1:0]                    host_wdata,
   output logic [BYTE_W*(1<<ADDR_W)-1:0]        regs_flat,
   output logic                                 wr_valid,
   output logic [ADDR_W-1:0]                    wr_addr,
   output logic [BYTE_W-1:0]                    wr_data,
   output logic [ADDR_W-1:0]                    ptr
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic asserted_rise_c, asserted_fall_c;
   logic tx_rise_c, tx_fall_c;
   logic rx_rise_c, rx_fall_c;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_inc_c;
   logic [BYTE_W-1:0]   tx_q, tx_d;
   logic                wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
   logic                i2c_we_c;
   logic                wr_allowed_c;
   logic [BYTE_W-1:0]   rx_byte_c;
   logic [BYTE_W-1:0]   regs_q [NUM_REGS];

   edge_detect u_asserted_edge (.clk(clk), .reset(reset), .din(slave_asserted),
                                .rise_c(asserted_rise_c), .fall_c(asserted_fall_c));
   edge_detect u_tx_edge       (.clk(clk), .reset(reset), .din(slave_tx_request),
                                .rise_c(tx_rise_c), .fall_c(tx_fall_c));
   edge_detect u_rx_edge       (.clk(clk), .reset(reset), .din(slave_rx_available),
                                .rise_c(rx_rise_c), .fall_c(rx_fall_c));

   assign rx_byte_c = bit_rev(slave_rx_buffer);
   assign ptr_inc_c = ptr_q + ADDR_W'(1);

`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   assign wr_allowed_c = (32'(ptr_q) < RO_BASE);
`else
   assign wr_allowed_c = 1'b1;
`endif

   // Next-state and next-output decode for the byte sequencer.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tx_d       = tx_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      i2c_we_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (asserted_rise_c) state_d = ADDRESSED;
         end
         ADDRESSED: begin
            if (rx_rise_c) begin
               ptr_d   = rx_byte_c[ADDR_W-1:0];
               state_d = WRITE;
            end else if (tx_rise_c && slave_in_tx_mode) begin
               tx_d    = bit_rev(regs_q[ptr_q]);
               ptr_d   = ptr_inc_c;
               state_d = READ;
            end
         end
         WRITE: begin
            if (rx_rise_c) begin
               ptr_d = ptr_inc_c;
               if (wr_allowed_c) begin
                  i2c_we_c   = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte_c;
               end
            end
         end
         READ: begin
            // Prefetch: the next byte loads while the previous ACK is still pending.
            if (tx_rise_c) begin
               tx_d  = bit_rev(regs_q[ptr_q]);
               ptr_d = ptr_inc_c;
            end
         end
         default: state_d = IDLE;
      endcase
      if (asserted_fall_c) state_d = IDLE;
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         tx_q       <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tx_q       <= tx_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Register file; the I2C write is issued last so it wins a same-index collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else begin
         if (host_we)  regs_q[host_addr] <= host_wdata;
         if (i2c_we_c) regs_q[ptr_q]     <= rx_byte_c;
      end
   end

   // Flatten the file for the rest of the design.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[BYTE_W*i +: BYTE_W] = regs_q[i];
   end

   assign slave_tx_buffer = tx_q;
   assign wr_valid        = wr_valid_q;
   assign wr_addr         = wr_addr_q;
   assign wr_data         = wr_data_q;
   assign ptr             = ptr_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed plus randomized I2C transactions against a register-array model.
module tb_i2c_reg_ctrl;

   localparam int unsigned NR = 16;
   localparam logic [7:0]  RV = 8'h00;

   logic         clk;
   logic         reset;
   logic         slave_asserted;
   logic         slave_in_tx_mode;
   logic         slave_tx_request;
   logic [7:0]   slave_rx_buffer;
   logic         slave_rx_available;
   logic [7:0]   slave_tx_buffer;
   logic         host_we;
   logic [3:0]   host_addr;
   logic [7:0]   host_wdata;
   logic [127:0] regs_flat;
   logic         wr_valid;
   logic [3:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [3:0]   ptr;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] m_regs [NR];
   int         m_ptr;

   i2c_reg_ctrl dut (
      .clk(clk), .reset(reset),
      .slave_asserted(slave_asserted), .slave_in_tx_mode(slave_in_tx_mode),
      .slave_tx_request(slave_tx_request), .slave_rx_buffer(slave_rx_buffer),
      .slave_rx_available(slave_rx_available), .slave_tx_buffer(slave_tx_buffer),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .regs_flat(regs_flat), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .ptr(ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] rev8(input logic [7:0] b);
      return {<<{b}};
   endfunction

   function automatic bit prot(input int idx);
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
      return idx >= 12;
`else
      return idx < 0;
`endif
   endfunction

   function automatic logic [127:0] m_flat();
      logic [127:0] f;
      for (int i = 0; i < NR; i++) f[8*i +: 8] = m_regs[i];
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = RV;
      m_ptr = 0;
   endtask

   task automatic start_bus();
      slave_asserted = 1'b1;
      tick();
   endtask

   task automatic stop_bus();
      slave_asserted   = 1'b0;
      slave_in_tx_mode = 1'b0;
      tick();
   endtask

   // First byte after the address: loads the pointer, no register write.
   task automatic wr_pointer(input logic [7:0] b);
      slave_rx_buffer    = rev8(b);
      slave_rx_available = 1'b1;
      tick();
      m_ptr = int'(b[3:0]);
      check("ptr_load", 128'(ptr), 128'(m_ptr));
      check("ptr_byte_no_wr", 128'(wr_valid), 128'(0));
      slave_rx_available = 1'b0;
      tick();
   endtask

   // Data byte, optionally with a host write in the same cycle.
   task automatic wr_data_byte(input logic [7:0] b, input bit hwe, input logic [3:0] ha, input logic [7:0] hd);
      slave_rx_buffer    = rev8(b);
      slave_rx_available = 1'b1;
      host_we    = hwe;
      host_addr  = ha;
      host_wdata = hd;
      tick();
      if (hwe) m_regs[ha] = hd;
      if (!prot(m_ptr)) begin
         m_regs[m_ptr] = b;
         check("wr_valid_pulse", 128'(wr_valid), 128'(1));
         check("wr_addr", 128'(wr_addr), 128'(m_ptr));
         check("wr_data", 128'(wr_data), 128'(b));
      end else begin
         check("wr_protected", 128'(wr_valid), 128'(0));
      end
      m_ptr = (m_ptr + 1) % NR;
      check("ptr_after_wr", 128'(ptr), 128'(m_ptr));
      slave_rx_available = 1'b0;
      host_we            = 1'b0;
      tick();
      check("wr_valid_single", 128'(wr_valid), 128'(0));
   endtask

   // Write-mode ACK pulse on tx_request: must be ignored.
   task automatic ack_pulse();
      logic [7:0] tx_before;
      tx_before        = slave_tx_buffer;
      slave_in_tx_mode = 1'b0;
      slave_tx_request = 1'b1;
      tick();
      check("ack_ptr_hold", 128'(ptr), 128'(m_ptr));
      check("ack_tx_hold", 128'(slave_tx_buffer), 128'(tx_before));
      slave_tx_request = 1'b0;
      tick();
   endtask

   // Master-read byte request, optionally with a host write in the same cycle.
   task automatic rd_byte(input bit hwe, input logic [3:0] ha, input logic [7:0] hd);
      logic [7:0] exp;
      exp              = rev8(m_regs[m_ptr]);
      slave_in_tx_mode = 1'b1;
      slave_tx_request = 1'b1;
      host_we    = hwe;
      host_addr  = ha;
      host_wdata = hd;
      tick();
      check("tx_byte", 128'(slave_tx_buffer), 128'(exp));
      if (hwe) m_regs[ha] = hd;
      m_ptr = (m_ptr + 1) % NR;
      check("ptr_after_rd", 128'(ptr), 128'(m_ptr));
      slave_tx_request = 1'b0;
      host_we          = 1'b0;
      tick();
   endtask

   // Byte arriving with no transaction open: must change nothing.
   task automatic stray_byte(input logic [7:0] b);
      slave_rx_buffer    = rev8(b);
      slave_rx_available = 1'b1;
      tick();
      check("stray_no_wr", 128'(wr_valid), 128'(0));
      slave_rx_available = 1'b0;
      tick();
      check("stray_ptr", 128'(ptr), 128'(m_ptr));
      check("stray_regs", regs_flat, m_flat());
   endtask

   initial begin
      logic [3:0] ha;
      int         n;
      reset              = 1'b1;
      slave_asserted     = 1'b0;
      slave_in_tx_mode   = 1'b0;
      slave_tx_request   = 1'b0;
      slave_rx_buffer    = 8'h00;
      slave_rx_available = 1'b0;
      host_we            = 1'b0;
      host_addr          = 4'h0;
      host_wdata         = 8'h00;
      model_reset();
      repeat (3) tick();
      check("rst_regs", regs_flat, m_flat());
      check("rst_ptr", 128'(ptr), 128'(0));
      check("rst_tx", 128'(slave_tx_buffer), 128'(0));
      check("rst_wr_valid", 128'(wr_valid), 128'(0));
      check("rst_wr_addr", 128'(wr_addr), 128'(0));
      check("rst_wr_data", 128'(wr_data), 128'(0));
      reset = 1'b0;
      tick();

      // Pointer write then two data bytes.
      start_bus();
      wr_pointer(8'h04);
      ack_pulse();
      wr_data_byte(8'hAA, 1'b0, 4'h0, 8'h00);
      wr_data_byte(8'hBB, 1'b0, 4'h0, 8'h00);
      stop_bus();
      check("t1_regs", regs_flat, m_flat());
      check("t1_ptr", 128'(ptr), 128'(6));

      // Pointer 14, repeated START, read across the wrap.
      start_bus();
      wr_pointer(8'h0E);
      stop_bus();
      start_bus();
      rd_byte(1'b0, 4'h0, 8'h00);
      rd_byte(1'b0, 4'h0, 8'h00);
      rd_byte(1'b0, 4'h0, 8'h00);
      stop_bus();
      check("t2_ptr", 128'(ptr), 128'(1));

      // Read from 2 with NACK after first byte: prefetch leaves ptr at 4.
      start_bus();
      wr_pointer(8'h02);
      stop_bus();
      start_bus();
      rd_byte(1'b0, 4'h0, 8'h00);
      rd_byte(1'b0, 4'h0, 8'h00);
      stop_bus();
      check("t3_ptr", 128'(ptr), 128'(4));
      stray_byte(8'h99);

      // Same-index collision: I2C wins; different index: both land.
      start_bus();
      wr_pointer(8'h05);
      wr_data_byte(8'h66, 1'b1, 4'h5, 8'h55);
      stop_bus();
      check("t4a_reg5", regs_flat[5*8 +: 8], 128'(8'h66));
      start_bus();
      wr_pointer(8'h05);
      wr_data_byte(8'h66, 1'b1, 4'h6, 8'h55);
      stop_bus();
      check("t4b_reg5", regs_flat[5*8 +: 8], 128'(8'h66));
      check("t4b_reg6", regs_flat[6*8 +: 8], 128'(8'h55));

      // Read concurrent with a host write to the same index returns the old value.
      start_bus();
      wr_pointer(8'h05);
      stop_bus();
      start_bus();
      rd_byte(1'b1, 4'h5, 8'hC3);
      stop_bus();
      check("t4c_regs", regs_flat, m_flat());

`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
      // Writes at or above the read-only base are dropped; ptr still advances.
      start_bus();
      wr_pointer(8'h0B);
      wr_data_byte(8'h11, 1'b0, 4'h0, 8'h00);
      wr_data_byte(8'h22, 1'b0, 4'h0, 8'h00);
      stop_bus();
      check("t6_reg11", regs_flat[11*8 +: 8], 128'(8'h11));
      check("t6_regs", regs_flat, m_flat());
      check("t6_ptr", 128'(ptr), 128'(13));
`endif

      // Randomized transactions with concurrent host traffic.
      for (int t = 0; t < 24; t++) begin
         start_bus();
         wr_pointer(8'($urandom_range(0, 255)));
         n = int'($urandom_range(1, 5));
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k < n; k++) begin
               ha = ($urandom_range(0, 1) == 0) ? 4'(m_ptr) : 4'($urandom_range(0, 15));
               wr_data_byte(8'($urandom), ($urandom_range(0, 2) == 0), ha, 8'($urandom));
            end
            stop_bus();
         end else begin
            stop_bus();
            start_bus();
            for (int k = 0; k < n; k++) begin
               ha = ($urandom_range(0, 1) == 0) ? 4'(m_ptr) : 4'($urandom_range(0, 15));
               rd_byte(($urandom_range(0, 2) == 0), ha, 8'($urandom));
            end
            stop_bus();
         end
         check("rand_regs", regs_flat, m_flat());
         check("rand_ptr", 128'(ptr), 128'(m_ptr));
      end

      // Reset in the middle of a write, after the pointer byte.
      start_bus();
      wr_pointer(8'h09);
      wr_data_byte(8'h3C, 1'b0, 4'h0, 8'h00);
      reset          = 1'b1;
      slave_asserted = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      check("t5_regs", regs_flat, m_flat());
      check("t5_ptr", 128'(ptr), 128'(0));
      check("t5_tx", 128'(slave_tx_buffer), 128'(0));
      check("t5_wr_valid", 128'(wr_valid), 128'(0));
      stray_byte(8'h7E);
      start_bus();
      wr_pointer(8'h01);
      wr_data_byte(8'h5A, 1'b0, 4'h0, 8'h00);
      stop_bus();
      check("t5_after_regs", regs_flat, m_flat());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
